sos_sample_sequencer: RTL

- Initiator side of the filter_sos sample interface.
- Buffers samples arriving on a valid/ready stream in a small FIFO and issues one sample_trig pulse per sample to the filter.
- Waits for filter_done, captures the filtered result and presents it on an output valid/ready stream.
- Watchdog times out a filter that never completes.
- Sits between the sample source (ADC/codec front end) and the top_filter cascade.

---
 rtl/sos_sample_sequencer_if.sv | 26 ++
 rtl/sos_sample_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sos_sample_sequencer_if.sv
// Signal bundle between the sample sequencer and its environment.
// Carries the source stream, the filter handshake and the result stream.
interface sos_sample_sequencer_if #(
  parameter int DATA_SIZE = 24
);
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] filt_data_in;
  logic                 filt_sample_trig;
  logic [DATA_SIZE-1:0] filt_data_out;
  logic                 filt_done;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    input  in_data, in_valid, filt_data_out, filt_done, out_ready,
    output in_ready, filt_data_in, filt_sample_trig, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, filt_data_out, filt_done, out_ready,
    input  in_ready, filt_data_in, filt_sample_trig, out_data, out_valid
  );
endinterface

// File: rtl/sos_sample_sequencer.sv
// Buffers incoming samples, launches one filter operation per sample, guards it
// with a watchdog and hands the filtered result to the downstream stream.
module sos_sample_sequencer #(
  parameter int DATA_SIZE      = 24,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  sos_sample_sequencer_if.master bus,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT} state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [WD_W-1:0]      wdog_q;
  logic [DATA_SIZE-1:0] filt_data_q, out_data_q;
  logic                 trig_q, out_valid_q, timeout_q;
  logic                 full, empty, push, launch, capture, expire;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;

  assign bus.in_ready         = !full;
  assign bus.filt_data_in     = filt_data_q;
  assign bus.filt_sample_trig = trig_q;
  assign bus.out_data         = out_data_q;
  assign bus.out_valid        = out_valid_q;
  assign busy                 = (state_q != IDLE);
  assign timeout_err          = timeout_q;

  // Storage has no reset; emptiness is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (launch) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, launch})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A completion on the expiry edge takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !out_valid_q) begin
          launch  = 1'b1;
          state_d = TRIG;
        end
      end
      TRIG: state_d = WAIT;
      WAIT: begin
        if (bus.filt_done) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (wdog_q == WD_LAST) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_data_q <= '0;
      out_data_q  <= '0;
      trig_q      <= 1'b0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      trig_q    <= launch;
      timeout_q <= expire;
      if (launch) filt_data_q <= mem[rd_ptr_q];
      if (state_q == TRIG)      wdog_q <= '0;
      else if (state_q == WAIT) wdog_q <= wdog_q + WD_ONE;
      if (capture) begin
        out_data_q  <= bus.filt_data_out;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule
